// File: rtl/add_arbiter_pkg.sv
// add_arbiter_pkg: shared definitions for the add_arbiter slice.
//   state_t  : FSM state encodings ST_IDLE / ST_EXEC / ST_RESP (2 bits)
//   next_ptr : circular successor of a requester index
package add_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Requester after g, wrapping to 0 past the last one (NREQ need not be 2**k).
    function automatic int next_ptr(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/add_arbiter_add.sv
// add: plain unsigned W-bit adder used as the shared datapath.
//   a, b in  W  operands
//   sum  out W  a + b modulo 2**W (callers zero-extend to keep the carry)
module add #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/add_arbiter_rr_pick.sv
// rr_pick: purely combinational round-robin priority picker.
//   req   in  NREQ  request vector
//   ptr   in  IDW   index with highest priority this cycle
//   grant out NREQ  one-hot grant of the first set bit at or after ptr (circular)
//   idx   out IDW   index of that bit (0 when nothing requested)
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic found;
    int   pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            // Walk ptr, ptr+1, ... modulo NREQ; first hit wins.
            pos = int'(ptr) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: shares one adder between NREQ requesters using round-robin
// arbitration; each granted operand pair produces one response.
//   Clk, Rst_n         clock, asynchronous active-low reset
//   req_valid/req_ready per-requester handshake (req_ready one-hot grant)
//   req_a, req_b       flattened operands, slice i = [i*DATAWIDTH +: DATAWIDTH]
//   rsp_valid/rsp_ready response handshake
//   rsp_id, rsp_sum, rsp_ovf  owner, result, carry out
//   busy               high whenever the FSM is not idle
// Optional build macro ADD_ARB_SAT_EN: saturate rsp_sum to all-ones on carry.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both 1.
// req_ready is only ever raised in IDLE for one cycle toward the chosen
// requester; rsp_valid stays high with stable payload until rsp_ready.
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4,
    parameter int IDW       = 2
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*DATAWIDTH-1:0] req_a,
    input  logic [NREQ*DATAWIDTH-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [DATAWIDTH-1:0]      rsp_sum,
    output logic                      rsp_ovf,
    output logic                      busy
);

    state_t               state;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       id_q;
    logic [DATAWIDTH-1:0] a_q;
    logic [DATAWIDTH-1:0] b_q;
    logic [DATAWIDTH:0]   sum_w;
    logic [NREQ-1:0]      pick_grant;
    logic [IDW-1:0]       pick_idx;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    add #(.W(DATAWIDTH + 1)) u_add (
        .a   ({1'b0, a_q}),
        .b   ({1'b0, b_q}),
        .sum (sum_w)
    );

    // Grant is combinational so the requester sees it in the cycle it is
    // chosen; gating with Rst_n keeps it low while reset is asserted.
    assign req_ready = (state == ST_IDLE && Rst_n) ? pick_grant : '0;
    assign rsp_id    = id_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_ovf   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        a_q    <= req_a[int'(pick_idx)*DATAWIDTH +: DATAWIDTH];
                        b_q    <= req_b[int'(pick_idx)*DATAWIDTH +: DATAWIDTH];
                        id_q   <= pick_idx;
                        // Winner drops to lowest priority next time.
                        rr_ptr <= IDW'(next_ptr(int'(pick_idx), NREQ));
                        busy   <= 1'b1;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
`ifdef ADD_ARB_SAT_EN
                    rsp_sum <= sum_w[DATAWIDTH] ? {DATAWIDTH{1'b1}} : sum_w[DATAWIDTH-1:0];
`else
                    rsp_sum <= sum_w[DATAWIDTH-1:0];
`endif
                    rsp_ovf   <= sum_w[DATAWIDTH];
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_arbiter.sv
module tb_add_arbiter;

    localparam int DW   = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int EW   = IDW + 1 + DW;

    logic                 Clk;
    logic                 Rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DW-1:0]   req_a;
    logic [NREQ*DW-1:0]   req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [DW-1:0]        rsp_sum;
    logic                 rsp_ovf;
    logic                 busy;

    int n_checks;
    int n_fail;

    logic [EW-1:0] exp_q[$];

    add_arbiter #(.DATAWIDTH(DW), .NREQ(NREQ), .IDW(IDW)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        step();
        step();
        Rst_n = 1'b1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int s;
        s = int'(a) + int'(b);
`ifdef ADD_ARB_SAT_EN
        if (s >= (1 << DW)) return {DW{1'b1}};
`endif
        return DW'(s % (1 << DW));
    endfunction

    function automatic logic exp_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (int'(a) + int'(b)) >= (1 << DW);
    endfunction

    task automatic randomize_operands();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*DW +: DW] = DW'($urandom_range(0, 255));
            req_b[i*DW +: DW] = DW'($urandom_range(0, 255));
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [NREQ-1:0] valid;
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [NREQ-1:0] ready;
        logic [IDW-1:0]  id;
        logic [DW-1:0]   sum;
        logic            ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [NREQ-1:0] onehot;
        logic [EW-1:0]   e;
        int m_ptr, m_age, m_next, g;

        n_checks = 0;
        n_fail   = 0;

`ifdef ADD_ARB_SAT_EN
        vecs[0] = '{4'b0100, 8'h12, 8'h34, 4'b0100, 2'd2, 8'h46, 1'b0};
        vecs[1] = '{4'b0001, 8'hF0, 8'h20, 4'b0001, 2'd0, 8'hFF, 1'b1};
        vecs[2] = '{4'b1000, 8'hFF, 8'hFF, 4'b1000, 2'd3, 8'hFF, 1'b1};
        vecs[3] = '{4'b0010, 8'hFF, 8'h01, 4'b0010, 2'd1, 8'hFF, 1'b1};
`else
        vecs[0] = '{4'b0100, 8'h12, 8'h34, 4'b0100, 2'd2, 8'h46, 1'b0};
        vecs[1] = '{4'b0001, 8'hF0, 8'h20, 4'b0001, 2'd0, 8'h10, 1'b1};
        vecs[2] = '{4'b1000, 8'hFF, 8'hFF, 4'b1000, 2'd3, 8'hFE, 1'b1};
        vecs[3] = '{4'b0010, 8'hFF, 8'h01, 4'b0010, 2'd1, 8'h00, 1'b1};
`endif
        vecs[4] = '{4'b0001, 8'h00, 8'h00, 4'b0001, 2'd0, 8'h00, 1'b0};
        vecs[5] = '{4'b1000, 8'h80, 8'h7F, 4'b1000, 2'd3, 8'hFF, 1'b0};

        // ---- reset state (requests asserted must not leak a grant) ----
        Rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b0;
        randomize_operands();
        #1;
        check("reset_req_ready", 32'(req_ready), 32'(0));
        check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset_rsp_id",    32'(rsp_id),    32'(0));
        check("reset_rsp_sum",   32'(rsp_sum),   32'(0));
        check("reset_rsp_ovf",   32'(rsp_ovf),   32'(0));
        check("reset_busy",      32'(busy),      32'(0));
        step();
        step();
        Rst_n = 1'b1;

        // ---- all four held valid: grants 0,1,2,3,0 every 3 cycles ----
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*DW +: DW] = DW'(16 * (i + 1));
            req_b[i*DW +: DW] = 8'h0F;
        end
        for (int c = 0; c < 15; c++) begin
            g = (c / 3) % NREQ;
            onehot = '0;
            if (c % 3 == 0) onehot[g] = 1'b1;
            #1;
            check("rr_req_ready", 32'(req_ready), 32'(onehot));
            check("rr_busy",      32'(busy),      32'(c % 3 != 0));
            check("rr_rsp_valid", 32'(rsp_valid), 32'(c % 3 == 2));
            if (c % 3 == 2) begin
                check("rr_rsp_id",  32'(rsp_id),  32'(g));
                check("rr_rsp_sum", 32'(rsp_sum), 32'(16 * (g + 1) + 15));
            end
            step();
        end
        req_valid = '0;

        // ---- skip and wrap: ptr is now 1, only 3 and 0 requesting ----
        req_valid = 4'b1001;
        for (int c = 0; c < 4; c++) begin
            onehot = (c == 0) ? 4'b1000 : (c == 3) ? 4'b0001 : 4'b0000;
            #1;
            check("wrap_req_ready", 32'(req_ready), 32'(onehot));
            step();
        end
        req_valid = '0;
        step();
        step();

        // ---- backpressure: 5 cycles of rsp_ready=0 in RESP ----
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        req_a[1*DW +: DW] = 8'h03;
        req_b[1*DW +: DW] = 8'h04;
        #1;
        check("bp_grant", 32'(req_ready), 32'(4'b0010));
        step();
        req_valid = '0;
        step();
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_rsp_valid", 32'(rsp_valid), 32'(1));
            check("bp_rsp_id",    32'(rsp_id),    32'(1));
            check("bp_rsp_sum",   32'(rsp_sum),   32'(8'h07));
            check("bp_busy",      32'(busy),      32'(1));
            check("bp_req_ready", 32'(req_ready), 32'(0));
            step();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        step();
        #1;
        check("bp_release_valid", 32'(rsp_valid), 32'(0));
        check("bp_release_busy",  32'(busy),      32'(0));
        rsp_ready = 1'b0;

        // ---- table of single-requester transactions ----
        foreach (vecs[v]) begin
            randomize_operands();
            for (int i = 0; i < NREQ; i++) begin
                if (vecs[v].valid[i]) begin
                    req_a[i*DW +: DW] = vecs[v].a;
                    req_b[i*DW +: DW] = vecs[v].b;
                end
            end
            req_valid = vecs[v].valid;
            rsp_ready = 1'b0;
            #1;
            check("vec_req_ready", 32'(req_ready), 32'(vecs[v].ready));
            step();
            req_valid = '0;
            randomize_operands();
            step();
            #1;
            check("vec_rsp_valid", 32'(rsp_valid), 32'(1));
            check("vec_rsp_id",    32'(rsp_id),    32'(vecs[v].id));
            check("vec_rsp_sum",   32'(rsp_sum),   32'(vecs[v].sum));
            check("vec_rsp_ovf",   32'(rsp_ovf),   32'(vecs[v].ovf));
            rsp_ready = 1'b1;
            step();
            #1;
            check("vec_done_valid", 32'(rsp_valid), 32'(0));
            rsp_ready = 1'b0;
        end

        // ---- reset in EXEC: op discarded, arbitration restarts at 0 ----
        step();
        req_valid = 4'b0100;
        #1;
        check("rst_exec_grant", 32'(req_ready), 32'(4'b0100));
        step();
        req_valid = '1;
        Rst_n = 1'b0;
        #1;
        check("rst_exec_req_ready", 32'(req_ready), 32'(0));
        check("rst_exec_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_exec_busy",      32'(busy),      32'(0));
        check("rst_exec_rsp_sum",   32'(rsp_sum),   32'(0));
        check("rst_exec_rsp_id",    32'(rsp_id),    32'(0));
        check("rst_exec_rsp_ovf",   32'(rsp_ovf),   32'(0));
        step();
        step();
        Rst_n = 1'b1;
        #1;
        check("rst_exec_regrant", 32'(req_ready), 32'(4'b0001));
        rsp_ready = 1'b1;
        step();
        req_valid = '0;
        #1;
        check("rst_exec_no_rsp", 32'(rsp_valid), 32'(0));
        step();
        #1;
        check("rst_exec_rsp_id_new", 32'(rsp_id), 32'(0));
        step();

        // ---- randomized traffic against a transaction-level model ----
        rsp_ready = 1'b0;
        req_valid = '0;
        do_reset();
        exp_q.delete();
        m_ptr = 0;
        m_age = -1;   // -1: free; n>=1: cycles since the grant
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid = NREQ'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req_valid = '0;
            randomize_operands();
            rsp_ready = 1'($urandom_range(0, 1));
            #1;
            onehot = '0;
            m_next = m_age;
            if (m_age < 0) begin
                if (req_valid != '0) begin
                    g = -1;
                    for (int k = 0; k < NREQ; k++) begin
                        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                    end
                    onehot[g] = 1'b1;
                    exp_q.push_back({IDW'(g),
                                     exp_ovf(req_a[g*DW +: DW], req_b[g*DW +: DW]),
                                     exp_sum(req_a[g*DW +: DW], req_b[g*DW +: DW])});
                    m_ptr  = (g + 1) % NREQ;
                    m_next = 1;
                end
            end else if (m_age == 1) begin
                m_next = 2;
            end else if (rsp_ready) begin
                m_next = -1;
            end
            check("rnd_req_ready", 32'(req_ready), 32'(onehot));
            check("rnd_busy",      32'(busy),      32'(m_age >= 1));
            check("rnd_rsp_valid", 32'(rsp_valid), 32'(m_age >= 2));
            if (m_age >= 2) begin
                e = exp_q[0];
                check("rnd_rsp_id",  32'(rsp_id),  32'(e[EW-1 -: IDW]));
                check("rnd_rsp_ovf", 32'(rsp_ovf), 32'(e[DW]));
                check("rnd_rsp_sum", 32'(rsp_sum), 32'(e[DW-1:0]));
                if (rsp_ready) void'(exp_q.pop_front());
            end
            m_age = m_next;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
